// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : Asynchronous serial receiver. rxd passes through a synchronizer,
//             a falling edge starts a frame, the start bit is qualified at
//             mid-bit, then DATA_BITS data bits (LSB first), an optional
//             even-parity bit and one stop bit are sampled every
//             baud_rate+1 clocks. A good byte lands in a one-entry buffer
//             with a valid/ready handshake.
//  Config   : define UART_RX_PARITY_EN to add a PARITY state that checks one
//             even-parity bit after the data bits. Undefined (default): no
//             parity bit in the frame and parity_err is tied low.
//  Ports    : clock       system clock, all state on rising edge
//             reset       asynchronous active-low reset
//             rx_en       receiver enable; low aborts a frame in progress
//             baud_rate   bit period minus one, latched at frame start
//             rxd         serial line, idle high, asynchronous to clock
//             rx_data     received byte buffer
//             rx_valid    rx_data holds an unconsumed byte
//             rx_ready    consumer accepts rx_data while rx_valid is high
//             frame_err   one-clock pulse: stop bit sampled low
//             overrun_err one-clock pulse: byte completed while buffer full
//             parity_err  one-clock pulse: parity mismatch
//             busy        receiver FSM is not idle
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_en,
  input  logic [15:0]          baud_rate,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  localparam logic [15:0] c_last_bit = 16'(DATA_BITS - 1);

  // Synchronizer and edge detect
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_line_prev;
  logic                   w_line;

  // Frame state
  state_t                 r_state;
  logic [15:0]            r_cnt;
  logic [15:0]            r_div;
  logic [15:0]            r_bit_cnt;
  logic [DATA_BITS-1:0]   r_shift;

  // Frame result, handed to the buffer stage one clock after the stop sample
  logic                   r_done;
  logic                   r_stop_ok;
  logic                   w_par_ok;
  logic                   w_good;
  logic                   w_accept;

  // Registered outputs
  logic [DATA_BITS-1:0]   r_rx_data;
  logic                   r_rx_valid;
  logic                   r_frame_err;
  logic                   r_overrun_err;

  assign w_line = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_par_ok;
  logic r_parity_err;
  assign w_par_ok   = r_par_ok;
  assign parity_err = r_parity_err;
`else
  assign w_par_ok   = 1'b1;
  assign parity_err = 1'b0;
`endif

  // A completed frame is accepted when the buffer is empty or is being
  // drained in this very clock; otherwise it is an overrun.
  assign w_good   = r_done && r_stop_ok && w_par_ok;
  assign w_accept = w_good && (!r_rx_valid || rx_ready);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_line_prev   <= 1'b1;
      r_state       <= S_IDLE;
      r_cnt         <= 16'd0;
      r_div         <= 16'd0;
      r_bit_cnt     <= 16'd0;
      r_shift       <= '0;
      r_done        <= 1'b0;
      r_stop_ok     <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit     <= 1'b0;
      r_par_ok      <= 1'b0;
      r_parity_err  <= 1'b0;
`endif
    end else begin
      r_line_prev <= w_line;
      r_done      <= 1'b0;

      // Buffer / error stage
      r_frame_err   <= r_done && !r_stop_ok;
      r_overrun_err <= w_good && r_rx_valid && !rx_ready;
`ifdef UART_RX_PARITY_EN
      r_parity_err  <= r_done && !r_par_ok;
`endif
      if (w_accept) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      // Receiver FSM
      if ((r_state != S_IDLE) && !rx_en) begin
        r_state   <= S_IDLE;
        r_cnt     <= 16'd0;
        r_bit_cnt <= 16'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            // Only a 1->0 transition starts a frame; a line stuck low does not.
            if (rx_en && r_line_prev && !w_line) begin
              r_state   <= S_START;
              r_div     <= baud_rate;
              r_cnt     <= 16'd0;
              r_bit_cnt <= 16'd0;
            end
          end

          S_START: begin
            if (r_cnt == (r_div >> 1)) begin
              r_cnt   <= 16'd0;
              // Line back high at mid-bit is a glitch: drop silently.
              r_state <= w_line ? S_IDLE : S_DATA;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end

          S_DATA: begin
            if (r_cnt == r_div) begin
              r_cnt   <= 16'd0;
              r_shift <= {w_line, r_shift[DATA_BITS-1:1]};
              if (r_bit_cnt == c_last_bit) begin
                r_bit_cnt <= 16'd0;
`ifdef UART_RX_PARITY_EN
                r_state   <= S_PARITY;
`else
                r_state   <= S_STOP;
`endif
              end else begin
                r_bit_cnt <= r_bit_cnt + 16'd1;
              end
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end

`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (r_cnt == r_div) begin
              r_cnt     <= 16'd0;
              r_par_bit <= w_line;
              r_state   <= S_STOP;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
`endif

          S_STOP: begin
            if (r_cnt == r_div) begin
              r_cnt     <= 16'd0;
              r_done    <= 1'b1;
              r_stop_ok <= w_line;
`ifdef UART_RX_PARITY_EN
              // Even parity: data bits plus parity bit hold an even count of ones.
              r_par_ok  <= ((^r_shift) == r_par_bit);
`endif
              r_state   <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
          end
        endcase
      end
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;
  assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx. Drives serial frames bit by
//             bit, tracks the expected buffer contents with a small model
//             (valid flag + byte) and counts error pulses from a monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

  localparam int DATA_BITS   = 8;
  localparam int SYNC_STAGES = 2;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic                 clock     = 1'b0;
  logic                 reset     = 1'b0;
  logic                 rx_en     = 1'b0;
  logic [15:0]          baud_rate = 16'd15;
  logic                 rxd       = 1'b1;
  logic                 rx_ready  = 1'b0;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 overrun_err;
  logic                 parity_err;
  logic                 busy;

  uart_rx #(
    .DATA_BITS   (DATA_BITS),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_en       (rx_en),
    .baud_rate   (baud_rate),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: pulse counters and the cycle at which rx_valid last rose.
  int   n_ferr = 0, n_oerr = 0, n_perr = 0;
  int   rise_cyc = 0;
  logic prev_valid = 1'b0;
  always @(negedge clock) begin
    if (frame_err === 1'b1)   n_ferr = n_ferr + 1;
    if (overrun_err === 1'b1) n_oerr = n_oerr + 1;
    if (parity_err === 1'b1)  n_perr = n_perr + 1;
    if (rx_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
    prev_valid = rx_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int tests = 0, fails = 0;
  int start_cyc = 0;
  int base_f, base_o, base_p;
  logic                 m_valid = 1'b0;
  logic [DATA_BITS-1:0] m_data  = '0;
  logic                 busy_before, busy_after;
  logic [DATA_BITS-1:0] rnd_data;
  logic                 rnd_stop, rnd_consume;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    base_f = n_ferr;
    base_o = n_oerr;
    base_p = n_perr;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    tick(int'(baud_rate) + 1);
  endtask

  // Start bit, data LSB first, optional even parity (par_flip inverts it),
  // stop bit, then enough idle for the result to reach the buffer.
  task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop, input logic par_flip);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) send_bit(d[i]);
    if (PAR_BITS != 0) send_bit((^d) ^ par_flip);
    send_bit(stop);
    tick(SYNC_STAGES + 4 + int'(baud_rate >> 1));
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    m_valid  = 1'b0;
  endtask

  // Clocks from driving the start bit to rx_valid loading: synchronizer,
  // edge detect, half-bit start qualification, one full bit per remaining
  // sample, then one clock into the buffer.
  function automatic int load_offset(input int div);
    return SYNC_STAGES + 1 + (div / 2) + 1 + (DATA_BITS + PAR_BITS + 1) * (div + 1) + 1;
  endfunction

  initial begin
    // ---------------- reset state ----------------
    tick(4);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_busy", busy, 0);
    check("reset_errs", {frame_err, overrun_err, parity_err}, 0);
    reset = 1'b1;
    rx_en = 1'b1;
    tick(4);
    check("idle_busy", busy, 0);

    // ---------------- 0xA5 latency ----------------
    baud_rate = 16'd15;
    snap();
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5_latency", rise_cyc - start_cyc, SYNC_STAGES + 1 + 153 + PAR_BITS * 16);
    check("a5_valid", rx_valid, 1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_no_err", (n_ferr - base_f) + (n_oerr - base_o) + (n_perr - base_p), 0);
    consume();
    check("a5_consumed", rx_valid, 0);

    // ---------------- false start ----------------
    snap();
    rxd = 1'b0;
    tick(5);
    check("false_start_busy", busy, 1);
    rxd = 1'b1;
    tick(20);
    check("false_start_idle", busy, 0);
    check("false_start_valid", rx_valid, 0);
    check("false_start_no_err", (n_ferr - base_f) + (n_oerr - base_o) + (n_perr - base_p), 0);

    // ---------------- framing error, line held low ----------------
    snap();
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(48);
    check("frame_err_pulses", n_ferr - base_f, 1);
    check("frame_err_valid", rx_valid, 0);
    check("frame_err_no_retrigger", busy, 0);
    rxd = 1'b1;
    tick(4);

    // ---------------- overrun ----------------
    snap();
    send_frame(8'h11, 1'b1, 1'b0);
    check("ovr_first_data", rx_data, 8'h11);
    send_frame(8'h22, 1'b1, 1'b0);
    check("ovr_pulses", n_oerr - base_o, 1);
    check("ovr_kept_data", rx_data, 8'h11);
    check("ovr_still_valid", rx_valid, 1);
    consume();
    check("ovr_consumed", rx_valid, 0);

    // Second byte completes in the same clock the first is consumed.
    send_frame(8'h11, 1'b1, 1'b0);
    snap();
    fork
      send_frame(8'h22, 1'b1, 1'b0);
      begin
        tick(load_offset(int'(baud_rate)) - 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    check("same_clk_data", rx_data, 8'h22);
    check("same_clk_valid", rx_valid, 1);
    check("same_clk_no_ovr", n_oerr - base_o, 0);
    consume();

    // ---------------- rx_en abort in data bit 3 ----------------
    snap();
    fork
      send_frame(8'hC3, 1'b1, 1'b0);
      begin
        tick(SYNC_STAGES + 1 + 8 + 3 * 16 + 8);
        busy_before = busy;
        rx_en = 1'b0;
        tick(1);
        busy_after = busy;
      end
    join
    rx_en = 1'b1;
    tick(4);
    check("abort_busy_before", busy_before, 1);
    check("abort_busy_after", busy_after, 0);
    check("abort_no_valid", rx_valid, 0);
    check("abort_no_err", (n_ferr - base_f) + (n_oerr - base_o) + (n_perr - base_p), 0);
    send_frame(8'h5A, 1'b1, 1'b0);
    check("after_abort_data", rx_data, 8'h5A);
    check("after_abort_valid", rx_valid, 1);
    consume();

`ifdef UART_RX_PARITY_EN
    // ---------------- parity ----------------
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    check("parity_bad_pulse", n_perr - base_p, 1);
    check("parity_bad_valid", rx_valid, 0);
    send_frame(8'h07, 1'b1, 1'b0);
    check("parity_good_data", rx_data, 8'h07);
    check("parity_good_valid", rx_valid, 1);
    consume();
`endif

    // ---------------- reset mid-frame ----------------
    send_frame(8'h96, 1'b1, 1'b0);
    rxd = 1'b0;
    tick(40);
    check("midrst_busy", busy, 1);
    reset = 1'b0;
    rxd   = 1'b1;
    #2;
    check("midrst_async_busy", busy, 0);
    check("midrst_async_valid", rx_valid, 0);
    check("midrst_async_data", rx_data, 0);
    tick(3);
    reset = 1'b1;
    m_valid = 1'b0;
    tick(30);
    check("midrst_stays_idle", busy, 0);

    // ---------------- randomized frames against the model ----------------
    for (int k = 0; k < 24; k++) begin
      baud_rate   = 16'($urandom_range(24, 3));
      rnd_data    = DATA_BITS'($urandom);
      rnd_stop    = ($urandom_range(4, 0) != 0);
      rnd_consume = ($urandom_range(2, 0) != 0);
      if (rnd_consume) consume();
      snap();
      send_frame(rnd_data, rnd_stop, 1'b0);
      rxd = 1'b1;
      tick(4);
      check("rnd_frame_err", n_ferr - base_f, rnd_stop ? 0 : 1);
      check("rnd_overrun", n_oerr - base_o, (rnd_stop && m_valid) ? 1 : 0);
      check("rnd_parity", n_perr - base_p, 0);
      if (rnd_stop && !m_valid) begin
        m_valid = 1'b1;
        m_data  = rnd_data;
      end
      check("rnd_valid", rx_valid, m_valid);
      if (m_valid) check("rnd_data", rx_data, m_data);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
